// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB full-speed TX line encoder.
//   tx_state_e   encoder FSM states
//   LINE_*       {dp,dm} line levels
//   STUFF_LIMIT  consecutive 1s that force a stuffed 0
//   EOP_SE0_BITS bit periods of SE0 in the end-of-packet sequence
//   line_toggle  NRZI transition helper (J<->K)
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int STUFF_LIMIT  = 6;
  localparam int EOP_SE0_BITS = 2;

  // NRZI "0": flip the differential state. SE0 never reaches here during data.
  function automatic logic [1:0] line_toggle(input logic [1:0] line);
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// usb_bit_timer: bit-period counter for the USB TX encoder.
//   clk, n_rst  clock, async active-low reset
//   clear       synchronous clear to 0 (dominates enable)
//   enable      count 0..CLKS_PER_BIT-1 and wrap
//   bit_tick    high in the last clk cycle of each bit period
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (bit_tick) cnt <= '0;
    else if (enable)   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed serial line encoder (bit stuffing, NRZI, EOP).
//   clk, n_rst  clock, async active-low reset
//   tx_start    one-cycle pulse, starts a packet from IDLE
//   serial_in   current serial bit from the upstream shifter
//   eop         level request to end the packet, sampled at a DATA bit tick
//   shift       one-cycle strobe, upstream shifter advances
//   stuffing    high for the whole bit period of a stuffed bit
//   busy        high outside IDLE
//   eop_done    one-cycle pulse on the tick that returns to IDLE
//   dp, dm      registered differential pair
// Build option: define USB_TX_STUFF_EN to enable bit stuffing. Without it the
// ones counter and STUFF state are dropped and runs of 1s go out raw.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_start,
  input  logic serial_in,
  input  logic eop,
  output logic shift,
  output logic stuffing,
  output logic busy,
  output logic eop_done,
  output logic dp,
  output logic dm
);

  tx_state_e   state, state_n;
  logic [1:0]  line, line_n;
  logic        se0_cnt, se0_cnt_n;
  logic        bit_tick;

  assign busy = (state != ST_IDLE);
  assign dp   = line[1];
  assign dm   = line[0];

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (state == ST_IDLE),
    .enable   (busy),
    .bit_tick (bit_tick)
  );

`ifdef USB_TX_STUFF_EN
  logic [2:0] ones, ones_n;
  logic [2:0] ones_inc;

  assign ones_inc = ones + 3'd1;
  assign stuffing = (state == ST_STUFF);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ones <= '0;
    else        ones <= ones_n;
  end
`else
  assign stuffing = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      line    <= LINE_J;
      se0_cnt <= 1'b0;
    end else begin
      state   <= state_n;
      line    <= line_n;
      se0_cnt <= se0_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    line_n    = line;
    se0_cnt_n = se0_cnt;
    shift     = 1'b0;
    eop_done  = 1'b0;
`ifdef USB_TX_STUFF_EN
    ones_n    = ones;
`endif
    case (state)
      ST_IDLE: begin
        // The first DATA period is still J: it stretches idle by one bit.
        if (tx_start) begin
          state_n = ST_DATA;
          line_n  = LINE_J;
`ifdef USB_TX_STUFF_EN
          ones_n  = '0;
`endif
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (eop) begin
            line_n    = LINE_SE0;
            se0_cnt_n = 1'b0;
            state_n   = ST_EOP_SE0;
          end else begin
            shift = 1'b1;
            if (!serial_in) begin
              line_n = line_toggle(line);
`ifdef USB_TX_STUFF_EN
              ones_n = '0;
`endif
            end
`ifdef USB_TX_STUFF_EN
            else begin
              ones_n = ones_inc;
              if (ones_inc == 3'(STUFF_LIMIT)) state_n = ST_STUFF;
            end
`endif
          end
        end
      end
`ifdef USB_TX_STUFF_EN
      ST_STUFF: begin
        // The stuffed 0 is emitted at this tick; eop waits for the next DATA tick.
        if (bit_tick) begin
          line_n  = line_toggle(line);
          ones_n  = '0;
          state_n = ST_DATA;
        end
      end
`endif
      ST_EOP_SE0: begin
        if (bit_tick) begin
          if (se0_cnt == 1'(EOP_SE0_BITS - 1)) begin
            line_n  = LINE_J;
            state_n = ST_EOP_J;
          end else begin
            se0_cnt_n = se0_cnt + 1'b1;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_tick) begin
          eop_done = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        line_n  = LINE_J;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: self-checking bench for usb_tx_encoder.
// A reference model turns each packet's bit list into a per-bit-period table
// of line level, shift and stuffing, and the bench compares every clk cycle.
module tb_usb_tx_encoder;

  localparam int CPB = 8;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst, tx_start, serial_in, eop;
  logic shift, stuffing, busy, eop_done, dp, dm;

  int checks = 0;
  int errors = 0;
  bit pkt[$];
  logic [1:0] obs_lvl [0:63];

  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_start  (tx_start),
    .serial_in (serial_in),
    .eop       (eop),
    .shift     (shift),
    .stuffing  (stuffing),
    .busy      (busy),
    .eop_done  (eop_done),
    .dp        (dp),
    .dm        (dm)
  );

  function automatic logic [1:0] tog(input logic [1:0] l);
    return (l == J) ? K : J;
  endfunction

  // Drive one packet from pkt[] and check every cycle against the model.
  // start_at >= 0 pulses a stray tx_start in that busy cycle.
  task automatic run_packet(input string name, input int start_at);
    logic [1:0] lv[$];
    bit sh[$];
    bit st[$];
    logic [1:0] cur;
    int ones, n, np, nstuff, c, p, ph, bad, nshift, nstf, ndone, idx, limit;
    bit sh_seen, exp_sh, exp_done;
    n = pkt.size(); cur = J; ones = 0; nstuff = 0;
    lv.push_back(J);                       // lead-in period
    foreach (pkt[i]) begin
      sh.push_back(1'b1); st.push_back(1'b0);
      if (pkt[i] == 1'b0) begin cur = tog(cur); ones = 0; end
      else ones++;
      lv.push_back(cur);
`ifdef USB_TX_STUFF_EN
      if (ones == 6) begin
        sh.push_back(1'b0); st.push_back(1'b1);
        cur = tog(cur); ones = 0; nstuff++;
        lv.push_back(cur);
      end
`endif
    end
    sh.push_back(1'b0); st.push_back(1'b0);  // period in which eop is sampled
    lv.push_back(SE0); lv.push_back(SE0); lv.push_back(J);
    repeat (3) begin sh.push_back(1'b0); st.push_back(1'b0); end
    np = lv.size();
    limit = np * CPB + 16;

    idx = 0; serial_in = pkt[0]; eop = 1'b0;
    @(negedge clk); tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    bad = 0; nshift = 0; nstf = 0; ndone = 0;
    for (c = 0; c < limit; c++) begin
      @(negedge clk);
      if (!busy) break;
      p = c / CPB; ph = c % CPB;
      if (p < np) begin
        exp_sh   = sh[p] && (ph == CPB - 1);
        exp_done = (p == np - 1) && (ph == CPB - 1);
        if ({dp, dm} !== lv[p] || shift !== exp_sh || stuffing !== st[p] || eop_done !== exp_done) begin
          bad++;
          if (bad <= 3)
            $display("  %s cycle %0d period %0d: line %b/%b shift %b/%b stuffing %b/%b eop_done %b/%b",
                     name, c, p, {dp, dm}, lv[p], shift, exp_sh, stuffing, st[p], eop_done, exp_done);
        end
      end else bad++;
      if (ph == CPB / 2 && p < 64) obs_lvl[p] = {dp, dm};
      nshift += int'(shift); nstf += int'(stuffing); ndone += int'(eop_done);
      sh_seen = shift;
      @(posedge clk); #1;
      if (sh_seen) idx++;
      serial_in = (idx < n) ? pkt[idx] : 1'b0;
      eop       = (idx >= n);
      tx_start  = (c == start_at);
    end
    tx_start = 1'b0; eop = 1'b0;

    checks++; if (c !== np * CPB) begin errors++; $display("FAIL %s busy_len: got %0d want %0d", name, c, np * CPB); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL %s cycle_trace: got %0d bad cycles want 0", name, bad); end
    checks++; if (nshift !== n) begin errors++; $display("FAIL %s shift_count: got %0d want %0d", name, nshift, n); end
    checks++; if (nstf !== nstuff * CPB) begin errors++; $display("FAIL %s stuff_cycles: got %0d want %0d", name, nstf, nstuff * CPB); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL %s eop_done_count: got %0d want 1", name, ndone); end
    checks++; if ({dp, dm} !== J || busy !== 1'b0) begin errors++; $display("FAIL %s idle_after: got line %b busy %b want 10 0", name, {dp, dm}, busy); end
  endtask

  task automatic test_reset();
    int bad;
    n_rst = 1'b0; tx_start = 1'b0; serial_in = 1'b0; eop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dp, dm, shift, stuffing, busy, eop_done} !== 6'b100000) begin
      errors++; $display("FAIL reset_state: got %b want 100000", {dp, dm, shift, stuffing, busy, eop_done});
    end
    n_rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({dp, dm} !== J || busy !== 1'b0 || shift !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_hold: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_sync();
    logic [1:0] want [0:8];
    int bad;
    want = '{J, K, J, K, J, K, J, K, K};
    pkt = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_packet("sync", -1);
    bad = 0;
    for (int i = 0; i < 9; i++) if (obs_lvl[i] !== want[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL sync_levels: got %0d wrong periods want 0", bad); end
  endtask

  task automatic test_stuffing();
    pkt = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_packet("stuff", -1);
    checks++; if (obs_lvl[7] !== K) begin errors++; $display("FAIL stuff_hold: got %b want %b", obs_lvl[7], K); end
`ifdef USB_TX_STUFF_EN
    checks++; if (obs_lvl[8] !== J || obs_lvl[10] !== J) begin errors++; $display("FAIL stuff_toggle: got %b %b want 10 10", obs_lvl[8], obs_lvl[10]); end
`else
    checks++; if (obs_lvl[8] !== K || obs_lvl[9] !== K) begin errors++; $display("FAIL raw_ones: got %b %b want 01 01", obs_lvl[8], obs_lvl[9]); end
`endif
  endtask

  task automatic test_eop_in_stuff();
    // Last six bits are 1s: eop rises while the stuffed bit is pending.
    pkt = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_packet("eop_in_stuff", -1);
  endtask

  task automatic test_busy_start();
    pkt = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    run_packet("busy_start", 20);
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 10; k++) begin
      pkt.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 3) != 0);
      run_packet($sformatf("rand%0d", k), -1);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    pkt = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    serial_in = 1'b0; eop = 1'b0;
    @(negedge clk); tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0; serial_in = 1'b1;
`ifdef USB_TX_STUFF_EN
    w = 0;
    while (stuffing !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    checks++; if (w >= 200) begin errors++; $display("FAIL reach_stuff: got timeout want stuffing"); end
`else
    repeat (30) @(negedge clk);
    w = 0;
`endif
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({dp, dm, stuffing, busy} !== 4'b1000) begin
      errors++; $display("FAIL reset_mid: got %b want 1000", {dp, dm, stuffing, busy});
    end
    @(negedge clk); n_rst = 1'b1; serial_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuffing();
    test_eop_in_stuff();
    test_busy_start();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
